mem_port_arbiter: RTL

- Shares the single unified instruction/data memory port between two requesters: the multicycle CPU controller path (fetch, lw, sw) and a DMA/program-loader port.
- Round-robin arbitration, one outstanding transaction at a time, req/ack handshake on each side and a req/ready handshake toward memory.
- Sits between the CPU datapath's memory-address mux output and the memory model. Lets the CPU tolerate variable memory latency instead of assuming single-cycle memory.

---
 rtl/mem_arb_pkg.sv | 11 +
 rtl/mem_arb_timeout.sv | 38 +++
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - state and owner encodings shared by mem_port_arbiter
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

endpackage

// File: rtl/mem_arb_timeout.sv
// rtl/mem_arb_timeout.sv - busy-cycle watchdog, expires in the TIMEOUT-th busy cycle
module mem_arb_timeout #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_d, count_q;

  // count_q holds the number of busy cycles already completed
  assign expire = run && (count_q == CW'(TIMEOUT - 1));

  // restart from zero whenever the arbiter is outside BUSY
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run && !expire) begin
      count_d = count_q + 1'b1;
    end
  end

  // counter register
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin CPU/DMA memory port arbiter; MEM_TIMEOUT_EN adds a busy watchdog
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              owner,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready
);

  logic [1:0]        state_d, state_q;
  logic              owner_d, owner_q;
  logic              m_we_d, m_we_q;
  logic [ADDR_W-1:0] m_addr_d, m_addr_q;
  logic [DATA_W-1:0] m_wdata_d, m_wdata_q;
  logic [DATA_W-1:0] rdata_d, rdata_q;
  logic              err_d, err_q;
  logic              grant_dma;
  logic              tmo_expire;

`ifdef MEM_TIMEOUT_EN
  mem_arb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q != ST_BUSY),
    .run    (state_q == ST_BUSY),
    .expire (tmo_expire)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign tmo_expire     = 1'b0;
`endif

  assign m_req   = (state_q == ST_BUSY);
  assign c_ack   = (state_q == ST_RESP) && (owner_q == OWN_CPU);
  assign d_ack   = (state_q == ST_RESP) && (owner_q == OWN_DMA);
  assign err     = err_q && (state_q == ST_RESP);
  assign owner   = owner_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign rdata   = rdata_q;

  // arbitration in IDLE, completion or watchdog in BUSY, single ack cycle in RESP
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    // DMA wins if it is alone, or on a tie when the CPU owned the last transaction
    grant_dma = d_req && (!c_req || (owner_q == OWN_CPU));
    case (state_q)
      ST_IDLE: begin
        if (c_req || d_req) begin
          owner_d   = grant_dma ? OWN_DMA : OWN_CPU;
          m_we_d    = grant_dma ? d_we    : c_we;
          m_addr_d  = grant_dma ? d_addr  : c_addr;
          m_wdata_d = grant_dma ? d_wdata : c_wdata;
          err_d     = 1'b0;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // a completion in the expiry cycle still counts as a normal completion
        if (m_ready) begin
          rdata_d = m_rdata;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (tmo_expire) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state and payload registers; reset hands the first tie to the CPU
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_DMA;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

endmodule
